// File: rtl/lsp_cb_rom_seq_pkg.sv
// Shared constants, codebook tables and FSM encoding for the LSP codebook ROM sequencer.
// Entries are Q15.16: one sign bit, 15 integer bits and 16 fraction bits.
package lsp_cb_pkg;

  localparam int WIDTH     = 32;
  localparam int NUM_CB    = 10;
  localparam int MAX_DEPTH = 16;
  localparam int IDX_W     = $clog2(MAX_DEPTH);
  localparam int CB_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef logic [IDX_W:0]                                depth_t;
  typedef logic [NUM_CB-1:0][IDX_W:0]                    size_tbl_t;
  typedef logic [NUM_CB-1:0][15:0]                       hz_tbl_t;
  typedef logic [NUM_CB-1:0][MAX_DEPTH-1:0][WIDTH-1:0]   rom_t;

  // Element [0] is the rightmost entry of each concatenation.
  localparam size_tbl_t CB_SIZE = {5'd4, 5'd8, 5'd8, 5'd16, 5'd16,
                                   5'd16, 5'd16, 5'd16, 5'd16, 5'd16};

  localparam hz_tbl_t CB_BASE_HZ = {16'd3200, 16'd2700, 16'd2200, 16'd1500, 16'd1300,
                                    16'd1100, 16'd800, 16'd500, 16'd250, 16'd100};
  localparam hz_tbl_t CB_STEP_HZ = {16'd150, 16'd140, 16'd120, 16'd100, 16'd90,
                                    16'd70, 16'd60, 16'd50, 16'd40, 16'd25};

  // Each codebook is an evenly spaced frequency grid; unused slots stay zero.
  function automatic rom_t build_rom();
    rom_t rom;
    int   hz;
    rom = '0;
    for (int c = 0; c < NUM_CB; c++) begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
        if (i < int'(CB_SIZE[c])) begin
          hz = int'(CB_BASE_HZ[c]) + int'(CB_STEP_HZ[c]) * i;
          rom[c][i] = WIDTH'(hz) << 16;
        end
      end
    end
    return rom;
  endfunction

  localparam rom_t CB_ROM = build_rom();

  function automatic depth_t cb_depth(input logic [CB_W-1:0] cb);
    depth_t d;
    if (int'(cb) < NUM_CB) begin
      d = CB_SIZE[cb];
    end else begin
      d = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/lsp_cb_rom_seq_table.sv
// Registered single-port codebook ROM; the enable freezes the data register during stalls.
module lsp_cb_table
  import lsp_cb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [CB_W-1:0]    cb_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [WIDTH-1:0]   data_o
);

  logic [WIDTH-1:0] rd_s;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    rd_s = '0;
    if (int'(cb_i) < NUM_CB) begin
      rd_s = CB_ROM[cb_i][idx_i];
    end else begin
      rd_s = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= rd_s;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/lsp_cb_rom_seq.sv
// Multi-codebook ROM sequencer: single-entry READ or whole-codebook SCAN through a
// two-stage pipeline (index register, ROM data register) with a valid/ready output.
module lsp_cb_rom_seq
  import lsp_cb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [CB_W-1:0]    cb_sel,
  input  logic [IDX_W-1:0]   addr,
  input  logic               abort,
  input  logic               dout_ready,
  output logic               busy,
  output logic               dout_valid,
  output logic [WIDTH-1:0]   dout,
  output logic [IDX_W-1:0]   dout_idx,
  output logic               dout_last,
  output logic [IDX_W:0]     cb_size,
  output logic               err
);

  state_e state_q, state_d;

  logic [CB_W-1:0]  cb_q;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [IDX_W:0]   end_q, end_d;
  logic [IDX_W:0]   cb_size_q;
  logic             busy_q, err_q;

  logic             s1_valid_q, s1_last_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             s2_valid_q, s2_last_q;
  logic [IDX_W-1:0] s2_idx_q;

  depth_t           req_depth_s;
  logic             req_bad_s;
  logic             adv_s, xfer_s;
  logic             accept_s, reject_s, issue_s, issue_last_s;

  assign req_depth_s  = cb_depth(cb_sel);
  assign req_bad_s    = (int'(cb_sel) >= NUM_CB) ||
                        ((mode == 1'b0) && ({1'b0, addr} >= req_depth_s));
  // Any held output beat stalls every stage, including the index counter.
  assign adv_s        = !(s2_valid_q && !dout_ready);
  assign xfer_s       = s2_valid_q && dout_ready;
  assign issue_last_s = (cnt_q == (end_q - (IDX_W+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    reject_s = 1'b0;
    issue_s  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && req_bad_s) begin
            reject_s = 1'b1;
          end else if (start) begin
            accept_s = 1'b1;
            state_d  = S_RUN;
          end else begin
            state_d  = S_IDLE;
          end
        end
        S_RUN: begin
          if (adv_s) begin
            issue_s = 1'b1;
            state_d = issue_last_s ? S_DRAIN : S_RUN;
          end else begin
            state_d = S_RUN;
          end
        end
        S_DRAIN: begin
          if (xfer_s && s2_last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Counter is one bit wider than the index so a 16-deep scan ends at 16, not 0.
  always_comb begin
    cnt_d = cnt_q;
    end_d = end_q;
    if (accept_s) begin
      if (mode) begin
        cnt_d = '0;
        end_d = req_depth_s;
      end else begin
        cnt_d = {1'b0, addr};
        end_d = {1'b0, addr} + (IDX_W+1)'(1);
      end
    end else if (issue_s) begin
      cnt_d = cnt_q + (IDX_W+1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cb_q      <= '0;
      cnt_q     <= '0;
      end_q     <= '0;
      cb_size_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      end_q  <= end_d;
      busy_q <= (state_d != S_IDLE);
      err_q  <= reject_s;
      if (accept_s || reject_s) begin
        cb_q      <= cb_sel;
        cb_size_q <= req_depth_s;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_idx_q   <= '0;
    end else if (abort) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (adv_s) begin
      s1_valid_q <= issue_s;
      s1_last_q  <= issue_s && issue_last_s;
      s1_idx_q   <= cnt_q[IDX_W-1:0];
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_idx_q   <= s1_idx_q;
    end
  end

  lsp_cb_table u_table (
    .clk    (clk),
    .rst    (rst),
    .en_i   (adv_s),
    .cb_i   (cb_q),
    .idx_i  (s1_idx_q),
    .data_o (dout)
  );

  assign busy       = busy_q;
  assign err        = err_q;
  assign cb_size    = cb_size_q;
  assign dout_valid = s2_valid_q;
  assign dout_idx   = s2_idx_q;
  assign dout_last  = s2_last_q;

endmodule
